jg_psg_bridge: RTL and testbench
================================

# jg_psg_bridge

Write bridge between the CPU I/O decoder and the two SN76489 sound chips. It converts the decoder's `sn1_wr` / `sn2_wr` selects into properly timed, chip-rate write pulses. It holds the Z80 in WAIT while a chip is busy latching. It sits directly downstream of the I/O decoder, in front of the two PSG cores.

## Interface
Parameters:
- `WE_CYCLES`, default 32: length of the write pulse, in `psg_ce` ticks (SN76489 READY-low time); legal range 1..63.

Ports:
- `clk_sys`  in  1  system clock; all state on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `psg_ce`  in  1  one-cycle clock enable at PSG chip rate.
- `sn1_wr`  in  1  decoder select for PSG 1 write; a level held for the whole CPU I/O write cycle.
- `sn2_wr`  in  1  decoder select for PSG 2 write; a level, as `sn1_wr`.
- `cpu_dout`  in  8  CPU data bus; valid while a select is high.
- `cpu_wait_n`  out  1  Z80 WAIT, active low.
- `psg_din`  out  8  data to both PSGs.
- `psg1_we_n`  out  1  PSG 1 write enable, active low.
- `psg2_we_n`  out  1  PSG 2 write enable, active low.
- `busy`  out  1  high whenever state is not IDLE.
- `overrun`  out  1  sticky flag: a write was dropped (only in the no-wait build).

## Operation
Reset values:
- `psg1_we_n` = `psg2_we_n` = 1, `cpu_wait_n` = 1.
- `psg_din` = 0x00, `busy` = 0, `overrun` = 0.
- State = IDLE; counter, served flag and pending slot all cleared.

Request detection:
- `req = (sn1_wr | sn2_wr) & ~served`.
- `served` sets in the cycle a request is accepted or parked.
- `served` clears in any cycle where both selects are low.
- One CPU access therefore produces exactly one PSG write, whatever its length.
- Both selects high at once: `sn1_wr` wins; the `sn2_wr` half is discarded.

States:
- IDLE:
  - If the pending slot is full, issue it (slot takes priority).
  - Otherwise, if `req`, latch `cpu_dout` into `psg_din` and latch the target chip.
  - On either, load counter with `WE_CYCLES-1` and go to PULSE.
- PULSE:
  - The targeted `psgN_we_n` is 0; the other stays 1.
  - On each `psg_ce`: if counter = 0, go to GAP; otherwise decrement.
- GAP:
  - Both `we_n` are 1.
  - On the next `psg_ce`, go to IDLE (guarantees at least one chip clock between pulses).

`psg_din` holds its value from accept until the next accept.

`cpu_wait_n` = 0 when `req` is high in any state, or when state = PULSE; otherwise 1. This output is combinational.

Reset mid-operation: returns immediately to the reset values; a partially issued pulse is abandoned.

## Timing
- Cycle T: select high in IDLE with `served` = 0. `cpu_wait_n` falls in T, combinationally.
- Cycle T+1: `psgN_we_n` = 0 and `psg_din` is valid.
- `we_n` stays low until the clock edge after the `WE_CYCLES`-th `psg_ce` tick counted in PULSE.
- `cpu_wait_n` returns to 1 in the first GAP cycle, provided no new request is present.
- A new request seen in GAP keeps `cpu_wait_n` low and is accepted on the first IDLE cycle.
- `psg_ce` stuck low: the block stays in PULSE or GAP indefinitely; no timeout.

## Configuration
`JG_PSG_WAIT_EN`:
- Defined: behaviour as above; no pending slot is built; `overrun` is tied to 0.
- Undefined: `cpu_wait_n` is tied to 1.
  - A `req` seen in PULSE or GAP is parked in a one-entry pending slot (data plus target) and `served` is set.
  - If the slot is already full, the write is dropped, `served` is set, and `overrun` sets. `overrun` clears only on reset.

## Test plan
- Reset release: all outputs at their reset values; `psg_ce` every 4 cycles with no selects -> `busy` = 0 and both `we_n` = 1 throughout.
- `sn1_wr` = 1 with `cpu_dout` = 0x9F, held 3 cycles, `WE_CYCLES` = 32 -> `cpu_wait_n` low in T; `psg1_we_n` low from T+1 for exactly 32 `psg_ce` ticks; `psg_din` = 0x9F; `psg2_we_n` stays 1.
- `sn2_wr` held high 500 cycles -> exactly one PSG 2 pulse, no second write.
- Back-to-back: `sn2_wr` 0xBF, then `sn1_wr` 0xDF asserted during GAP (wait build) -> `cpu_wait_n` stays low; second pulse begins on the first IDLE cycle; never both `we_n` low together.
- `sn1_wr` and `sn2_wr` both high with 0x55 -> only `psg1_we_n` pulses.
- No-wait build: three writes 0x11, 0x22, 0x33 in quick succession inside a single pulse -> 0x11 and 0x22 are issued in order; 0x33 is dropped and `overrun` = 1; `rst_n` low mid-pulse -> `we_n` goes to 1 and `overrun` to 0 immediately.

Source files
------------

// File: rtl/jg_psg_bridge.sv
// jg_psg_bridge
// Turns the I/O decoder's PSG selects into chip-rate write pulses for two
// SN76489 cores. Each CPU access (a select level of any length) yields
// exactly one PSG write. While a chip is latching, the Z80 is either held in
// WAIT or, in the no-wait build, the write is parked in a one-entry slot.
//
// Build option: define JG_PSG_WAIT_EN to stall the CPU through cpu_wait_n.
// When it is undefined, cpu_wait_n is tied high, a one-entry pending slot is
// built, and overrun flags writes that arrived while the slot was full.
//
// Ports:
//   clk_sys    in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   psg_ce     in   one-cycle enable at PSG chip rate
//   sn1_wr     in   PSG 1 select (level for whole I/O write cycle)
//   sn2_wr     in   PSG 2 select (level)
//   cpu_dout   in   CPU data bus, valid while a select is high
//   cpu_wait_n out  Z80 WAIT, active low (combinational)
//   psg_din    out  data to both PSGs
//   psg1_we_n  out  PSG 1 write enable, active low
//   psg2_we_n  out  PSG 2 write enable, active low
//   busy       out  high whenever not idle
//   overrun    out  sticky: a write was dropped (no-wait build only)
module jg_psg_bridge #(
  parameter int WE_CYCLES = 32
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       psg_ce,
  input  logic       sn1_wr,
  input  logic       sn2_wr,
  input  logic [7:0] cpu_dout,
  output logic       cpu_wait_n,
  output logic [7:0] psg_din,
  output logic       psg1_we_n,
  output logic       psg2_we_n,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  localparam logic [5:0] CNT_LOAD = 6'(WE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       served_q, served_d;
  logic [7:0] din_q, din_d;
  logic       tgt_q, tgt_d;
  logic       we1_n_q, we1_n_d;
  logic       we2_n_q, we2_n_d;
  logic       busy_q, busy_d;
  logic       any_sel;
  logic       req;
  logic       sel_tgt;
  logic       taken;

`ifndef JG_PSG_WAIT_EN
  logic       slot_full_q, slot_full_d;
  logic [7:0] slot_data_q, slot_data_d;
  logic       slot_tgt_q, slot_tgt_d;
  logic       overrun_q, overrun_d;
`endif

  // A select level counts as a new request only until it has been taken once;
  // served clears when both selects drop. tgt 0 = PSG 1, 1 = PSG 2, and PSG 1
  // wins when both selects are high.
  assign any_sel = sn1_wr | sn2_wr;
  assign req     = any_sel & ~served_q;
  assign sel_tgt = ~sn1_wr;

  // Next-state logic: IDLE launches a pulse (parked write first), PULSE counts
  // chip-rate ticks, GAP guarantees one chip clock between pulses.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    din_d    = din_q;
    tgt_d    = tgt_q;
    taken    = 1'b0;
`ifndef JG_PSG_WAIT_EN
    slot_full_d = slot_full_q;
    slot_data_d = slot_data_q;
    slot_tgt_d  = slot_tgt_q;
    overrun_d   = overrun_q;
`endif

    case (state_q)
      IDLE: begin
`ifndef JG_PSG_WAIT_EN
        if (slot_full_q) begin
          din_d       = slot_data_q;
          tgt_d       = slot_tgt_q;
          slot_full_d = 1'b0;
          cnt_d       = CNT_LOAD;
          state_d     = PULSE;
        end else
`endif
        if (req) begin
          din_d   = cpu_dout;
          tgt_d   = sel_tgt;
          taken   = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = PULSE;
        end
      end
      PULSE: begin
        if (psg_ce) begin
          if (cnt_q == 6'd0) begin
            state_d = GAP;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
      end
      GAP: begin
        if (psg_ce) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifndef JG_PSG_WAIT_EN
    // Without WAIT the CPU runs on, so a write during PULSE/GAP is parked, or
    // dropped with a sticky flag if a write is already parked.
    if ((state_q != IDLE) && req) begin
      taken = 1'b1;
      if (slot_full_q) begin
        overrun_d = 1'b1;
      end else begin
        slot_full_d = 1'b1;
        slot_data_d = cpu_dout;
        slot_tgt_d  = sel_tgt;
      end
    end
`endif

    served_d = any_sel ? (served_q | taken) : 1'b0;
    we1_n_d  = ~((state_d == PULSE) & ~tgt_d);
    we2_n_d  = ~((state_d == PULSE) & tgt_d);
    busy_d   = (state_d != IDLE);
  end

  // All state and the registered outputs.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      served_q <= 1'b0;
      din_q    <= 8'h00;
      tgt_q    <= 1'b0;
      we1_n_q  <= 1'b1;
      we2_n_q  <= 1'b1;
      busy_q   <= 1'b0;
`ifndef JG_PSG_WAIT_EN
      slot_full_q <= 1'b0;
      slot_data_q <= 8'h00;
      slot_tgt_q  <= 1'b0;
      overrun_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      served_q <= served_d;
      din_q    <= din_d;
      tgt_q    <= tgt_d;
      we1_n_q  <= we1_n_d;
      we2_n_q  <= we2_n_d;
      busy_q   <= busy_d;
`ifndef JG_PSG_WAIT_EN
      slot_full_q <= slot_full_d;
      slot_data_q <= slot_data_d;
      slot_tgt_q  <= slot_tgt_d;
      overrun_q   <= overrun_d;
`endif
    end
  end

  assign psg_din   = din_q;
  assign psg1_we_n = we1_n_q;
  assign psg2_we_n = we2_n_q;
  assign busy      = busy_q;

`ifdef JG_PSG_WAIT_EN
  // Stall the CPU from the moment a select is seen until the pulse ends.
  assign cpu_wait_n = ~(req | (state_q == PULSE));
  assign overrun    = 1'b0;
`else
  assign cpu_wait_n = 1'b1;
  assign overrun    = overrun_q;
`endif

endmodule

// File: tb/tb_jg_psg_bridge.sv
// tb_jg_psg_bridge
// Self-checking bench for jg_psg_bridge. A write-level model (pulse ticks
// remaining, a queue of parked writes) predicts every output each cycle; a
// pulse monitor records each PSG pulse's data and tick length so directed
// scenarios can be pinned with literal expectations. Matches either build via
// JG_PSG_WAIT_EN.
module tb_jg_psg_bridge;

  localparam int WE = 32;
`ifdef JG_PSG_WAIT_EN
  localparam bit WAIT_BUILD = 1'b1;
`else
  localparam bit WAIT_BUILD = 1'b0;
`endif

  logic       clk_sys = 1'b0;
  logic       rst_n   = 1'b0;
  logic       psg_ce  = 1'b0;
  logic       sn1_wr  = 1'b0;
  logic       sn2_wr  = 1'b0;
  logic [7:0] cpu_dout = 8'h00;
  logic       cpu_wait_n;
  logic [7:0] psg_din;
  logic       psg1_we_n;
  logic       psg2_we_n;
  logic       busy;
  logic       overrun;

  int tests  = 0;
  int failed = 0;
  bit ce_random = 1'b0;

  jg_psg_bridge #(.WE_CYCLES(WE)) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .psg_ce     (psg_ce),
    .sn1_wr     (sn1_wr),
    .sn2_wr     (sn2_wr),
    .cpu_dout   (cpu_dout),
    .cpu_wait_n (cpu_wait_n),
    .psg_din    (psg_din),
    .psg1_we_n  (psg1_we_n),
    .psg2_we_n  (psg2_we_n),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk_sys = ~clk_sys;

  // Chip-rate enable: every 4th cycle, or random density in the soak phase.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (ce_random) begin
        psg_ce = ($urandom_range(0, 2) == 0);
      end else begin
        ph = (ph + 1) % 4;
        psg_ce = (ph == 0);
      end
    end
  end

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [7:0] data;
    logic       tgt;
  } wr_t;

  wr_t        pend[$];
  int         m_ticks;
  bit         m_gap;
  bit         m_served;
  bit         m_tgt;
  bit         m_overrun;
  logic [7:0] m_din;

  // Advance the model one clock: a pulse is "ticks left to count"; after it
  // comes one gap that ends on the next chip tick.
  always @(posedge clk_sys or negedge rst_n) begin
    bit  anysel, req, taken, was_idle;
    wr_t w;
    if (!rst_n) begin
      m_ticks = 0; m_gap = 0; m_served = 0; m_tgt = 0; m_overrun = 0; m_din = 8'h00;
      pend.delete();
    end else begin
      anysel   = sn1_wr | sn2_wr;
      req      = anysel && !m_served;
      taken    = 0;
      was_idle = (m_ticks == 0) && !m_gap;
      if (was_idle) begin
        if (pend.size() > 0) begin
          w = pend.pop_front();
          m_din = w.data; m_tgt = w.tgt; m_ticks = WE;
        end else if (req) begin
          m_din = cpu_dout; m_tgt = !sn1_wr; m_ticks = WE; taken = 1;
        end
      end else if (m_ticks > 0) begin
        if (psg_ce) begin
          m_ticks = m_ticks - 1;
          if (m_ticks == 0) m_gap = 1;
        end
      end else if (psg_ce) begin
        m_gap = 0;
      end
      if (!WAIT_BUILD && !was_idle && req) begin
        taken = 1;
        if (pend.size() >= 1) m_overrun = 1;
        else begin
          w.data = cpu_dout; w.tgt = !sn1_wr;
          pend.push_back(w);
        end
      end
      m_served = anysel ? (m_served | taken) : 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare + pulse monitor ----------------
  logic       prev1 = 1'b1, prev2 = 1'b1;
  int         len1, len2;
  int         p1_cnt = 0, p2_cnt = 0;
  logic [7:0] p1_data[$], p2_data[$];
  int         p1_len[$];

  always @(negedge clk_sys) begin
    bit pulse, req_now;
    pulse   = (m_ticks > 0);
    req_now = (sn1_wr | sn2_wr) && !m_served;
    checkOutput("we1_n", {7'd0, psg1_we_n}, {7'd0, !(pulse && !m_tgt)});
    checkOutput("we2_n", {7'd0, psg2_we_n}, {7'd0, !(pulse && m_tgt)});
    checkOutput("busy", {7'd0, busy}, {7'd0, pulse || m_gap});
    checkOutput("din", psg_din, m_din);
    checkOutput("overrun", {7'd0, overrun}, {7'd0, m_overrun});
    checkOutput("wait_n", {7'd0, cpu_wait_n}, WAIT_BUILD ? {7'd0, !(req_now || pulse)} : 8'h01);
    checkOutput("we_exclusive", {7'd0, psg1_we_n | psg2_we_n}, 8'h01);

    if (prev1 && !psg1_we_n) begin p1_cnt++; p1_data.push_back(psg_din); len1 = 0; end
    if (!psg1_we_n && psg_ce) len1++;
    if (!prev1 && psg1_we_n) p1_len.push_back(len1);
    if (prev2 && !psg2_we_n) begin p2_cnt++; p2_data.push_back(psg_din); len2 = 0; end
    if (!psg2_we_n && psg_ce) len2++;
    prev1 = psg1_we_n;
    prev2 = psg2_we_n;
  end

  // ---------------- stimulus helpers ----------------
  task automatic applyStimulus(input logic s1, input logic s2, input logic [7:0] d);
    @(posedge clk_sys);
    #1;
    sn1_wr = s1; sn2_wr = s2; cpu_dout = d;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  // Wait until busy has been low for four cycles in a row, bounded.
  task automatic waitQuiet(input string name);
    int quiet;
    quiet = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk_sys); #1;
      if (busy) quiet = 0; else quiet++;
      if (quiet >= 4) return;
    end
    tests++; failed++;
    $display("[TB] FAIL %s: timeout busy=%b required 0", name, busy);
  endtask

  initial begin
    int c1, c2, seen;
    logic [7:0] d;

    // Reset state
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys); #1;
    checkOutput("rst_we1_n", {7'd0, psg1_we_n}, 8'h01);
    checkOutput("rst_we2_n", {7'd0, psg2_we_n}, 8'h01);
    checkOutput("rst_wait_n", {7'd0, cpu_wait_n}, 8'h01);
    checkOutput("rst_din", psg_din, 8'h00);
    checkOutput("rst_busy", {7'd0, busy}, 8'h00);
    checkOutput("rst_overrun", {7'd0, overrun}, 8'h00);
    @(posedge clk_sys); #1;
    rst_n = 1'b1;

    // Idle with chip ticks and no selects: nothing happens
    idleCycles(40);
    checkOutput("idle_pulses", 8'(p1_cnt + p2_cnt), 8'd0);

    // Single PSG 1 write 0x9F held 3 cycles
    c2 = p2_cnt;
    applyStimulus(1'b1, 1'b0, 8'h9F);
    @(negedge clk_sys); #1;
    checkOutput("t_wait_T", {7'd0, cpu_wait_n}, WAIT_BUILD ? 8'h00 : 8'h01);
    applyStimulus(1'b1, 1'b0, 8'h9F);
    @(negedge clk_sys); #1;
    checkOutput("t_we1_T1", {7'd0, psg1_we_n}, 8'h00);
    checkOutput("t_din_T1", psg_din, 8'h9F);
    applyStimulus(1'b1, 1'b0, 8'h9F);
    idleCycles(1);
    waitQuiet("single_idle");
    checkOutput("single_len", 8'(p1_len[$]), 8'(WE));
    checkOutput("single_cnt", 8'(p1_cnt), 8'd1);
    checkOutput("single_no_psg2", 8'(p2_cnt - c2), 8'd0);

    // PSG 2 select held 500 cycles: one write only
    c2 = p2_cnt;
    for (int i = 0; i < 500; i++) applyStimulus(1'b0, 1'b1, 8'hA5);
    idleCycles(1);
    waitQuiet("hold_idle");
    checkOutput("hold_one_write", 8'(p2_cnt - c2), 8'd1);
    checkOutput("hold_data", p2_data[$], 8'hA5);

    // Back-to-back: PSG 2 0xBF, then PSG 1 0xDF raised during the gap
    c1 = p1_cnt;
    applyStimulus(1'b0, 1'b1, 8'hBF);
    applyStimulus(1'b0, 1'b1, 8'hBF);
    idleCycles(1);
    seen = 0;
    for (int n = 0; n < 2000 && !seen; n++) begin
      @(negedge clk_sys); #1;
      if (busy && psg1_we_n && psg2_we_n) seen = 1;
    end
    checkOutput("b2b_gap_seen", 8'(seen), 8'd1);
    applyStimulus(1'b1, 1'b0, 8'hDF);
    @(negedge clk_sys); #1;
    checkOutput("b2b_wait_gap", {7'd0, cpu_wait_n}, WAIT_BUILD ? 8'h00 : 8'h01);
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (!psg1_we_n) seen = 1;
      else begin
        applyStimulus(1'b1, 1'b0, 8'hDF);
        @(negedge clk_sys); #1;
      end
    end
    checkOutput("b2b_second_start", 8'(seen), 8'd1);
    idleCycles(1);
    waitQuiet("b2b_idle");
    checkOutput("b2b_data", p1_data[$], 8'hDF);
    checkOutput("b2b_cnt", 8'(p1_cnt - c1), 8'd1);

    // Both selects high: PSG 1 wins
    c1 = p1_cnt; c2 = p2_cnt;
    applyStimulus(1'b1, 1'b1, 8'h55);
    applyStimulus(1'b1, 1'b1, 8'h55);
    idleCycles(1);
    waitQuiet("both_idle");
    checkOutput("both_psg1", 8'(p1_cnt - c1), 8'd1);
    checkOutput("both_psg2", 8'(p2_cnt - c2), 8'd0);
    checkOutput("both_data", p1_data[$], 8'h55);

    // Three quick writes inside one pulse
    c1 = p1_cnt;
    for (int k = 0; k < 3; k++) begin
      d = 8'h11 * 8'(k + 1);
      applyStimulus(1'b1, 1'b0, d);
      applyStimulus(1'b1, 1'b0, d);
      idleCycles(3);
    end
    @(negedge clk_sys); #1;
    checkOutput("three_overrun", {7'd0, overrun}, WAIT_BUILD ? 8'h00 : 8'h01);
    waitQuiet("three_idle");
    checkOutput("three_cnt", 8'(p1_cnt - c1), WAIT_BUILD ? 8'd1 : 8'd2);
    if (!WAIT_BUILD) begin
      checkOutput("three_first", p1_data[$-1], 8'h11);
      checkOutput("three_second", p1_data[$], 8'h22);
    end
    checkOutput("three_sticky", {7'd0, overrun}, WAIT_BUILD ? 8'h00 : 8'h01);

    // Reset mid-pulse
    applyStimulus(1'b1, 1'b0, 8'h77);
    applyStimulus(1'b1, 1'b0, 8'h77);
    idleCycles(10);
    checkOutput("midrst_in_pulse", {7'd0, psg1_we_n}, 8'h00);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_we1_n", {7'd0, psg1_we_n}, 8'h01);
    checkOutput("midrst_overrun", {7'd0, overrun}, 8'h00);
    checkOutput("midrst_busy", {7'd0, busy}, 8'h00);
    idleCycles(2);
    rst_n = 1'b1;
    idleCycles(4);

    // Randomised soak against the model
    ce_random = 1'b1;
    for (int it = 0; it < 300; it++) begin
      int sel, hold, gap;
      sel  = $urandom_range(1, 3);
      hold = $urandom_range(1, 6);
      gap  = $urandom_range(0, 40);
      d    = 8'($urandom);
      for (int h = 0; h < hold; h++) applyStimulus(sel[0], sel[1], d);
      idleCycles(gap);
    end
    ce_random = 1'b0;
    idleCycles(1);
    waitQuiet("soak_idle");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
